// File: rtl/fwd_wb_pipe.sv
// Result staging pipe between the execution units and the register-file write port.
// Units inject into fixed stages; staged results are forwarded to lookup ports youngest-first.
module fwd_wb_pipe #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int DEPTH = 7,
    parameter int NUM_UNITS = 5,
    parameter logic [4*NUM_UNITS-1:0] UNIT_STAGE = {4'd7, 4'd6, 4'd4, 4'd4, 4'd2},
    parameter int NUM_RD = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [NUM_UNITS*ADDR_W-1:0] unit_addr,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    input  logic [NUM_RD*ADDR_W-1:0]    lookup_addr,
    output logic [NUM_RD-1:0]           lookup_hit,
    output logic [NUM_RD*DATA_W-1:0]    lookup_data,
    output logic                        wb_valid,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        collision,
    output logic [7:0]                  drop_cnt
);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_chk
        if (UNIT_STAGE[4*u +: 4] < 1 || UNIT_STAGE[4*u +: 4] > DEPTH) begin : g_bad
            $error("fwd_wb_pipe: unit %0d injects into a stage outside 1..DEPTH", u);
        end
    end

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [7:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [DEPTH:1]    stg_valid;
    logic [ADDR_W-1:0] stg_addr [1:DEPTH];
    logic [DATA_W-1:0] stg_data [1:DEPTH];

    logic [DEPTH:1]    up_valid;
    logic [ADDR_W-1:0] up_addr [1:DEPTH];
    logic [DATA_W-1:0] up_data [1:DEPTH];

    logic [DEPTH:1]    nxt_valid;
    logic [ADDR_W-1:0] nxt_addr [1:DEPTH];
    logic [DATA_W-1:0] nxt_data [1:DEPTH];

    logic [7:0]        drops_now;
    logic              taken;

    // Stage 1 is fed by the permanently empty s[0].
    for (genvar k = 1; k <= DEPTH; k++) begin : g_up
        if (k == 1) begin : g_head
            assign up_valid[k] = 1'b0;
            assign up_addr[k]  = '0;
            assign up_data[k]  = '0;
        end else begin : g_body
            assign up_valid[k] = stg_valid[k-1];
            assign up_addr[k]  = stg_addr[k-1];
            assign up_data[k]  = stg_data[k-1];
        end
    end

    always_comb begin
        drops_now = '0;
        taken     = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            nxt_valid[k] = up_valid[k];
            nxt_addr[k]  = up_addr[k];
            nxt_data[k]  = up_data[k];
            taken        = 1'b0;
            // Lowest unit index claims the stage; later claimants and a displaced valid entry are lost.
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (unit_valid[u] && (int'(UNIT_STAGE[4*u +: 4]) == k)) begin
                    if (!taken) begin
                        taken        = 1'b1;
                        nxt_valid[k] = 1'b1;
                        nxt_addr[k]  = unit_addr[u*ADDR_W +: ADDR_W];
                        nxt_data[k]  = unit_data[u*DATA_W +: DATA_W];
                        if (up_valid[k]) drops_now = drops_now + 8'd1;
                    end else begin
                        drops_now = drops_now + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                stg_addr[k] <= '0;
                stg_data[k] <= '0;
            end
            collision <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            stg_valid <= nxt_valid;
            for (int k = 1; k <= DEPTH; k++) begin
                stg_addr[k] <= nxt_addr[k];
                stg_data[k] <= nxt_data[k];
            end
            if (drops_now != 8'd0) collision <= 1'b1;
            drop_cnt <= sat_add(drop_cnt, drops_now);
        end
    end

    // Scan oldest to youngest so the lowest matching stage is the last assignment.
    always_comb begin
        lookup_hit  = '0;
        lookup_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (stg_valid[k] && (stg_addr[k] == lookup_addr[r*ADDR_W +: ADDR_W])) begin
                    lookup_hit[r]                  = 1'b1;
                    lookup_data[r*DATA_W +: DATA_W] = stg_data[k];
                end
            end
        end
    end

    assign wb_valid = stg_valid[DEPTH];
    assign wb_addr  = stg_addr[DEPTH];
    assign wb_data  = stg_data[DEPTH];

endmodule

// File: tb/tb_fwd_wb_pipe.sv
// Bench for fwd_wb_pipe: directed vector table, corner sequences, and randomized traffic
// checked against a queue-of-records model of the staging pipe.
module tb_fwd_wb_pipe;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int DEPTH = 7;
    localparam int NU = 5;
    localparam int NR = 3;
    localparam int ST [NU] = '{2, 4, 4, 6, 7};

    logic              clk = 1'b0;
    logic              reset;
    logic [NU-1:0]     unit_valid;
    logic [NU*AW-1:0]  unit_addr;
    logic [NU*DW-1:0]  unit_data;
    logic [NR*AW-1:0]  lookup_addr;
    logic [NR-1:0]     lookup_hit;
    logic [NR*DW-1:0]  lookup_data;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              collision;
    logic [7:0]        drop_cnt;

    fwd_wb_pipe dut (
        .clk(clk), .reset(reset), .unit_valid(unit_valid), .unit_addr(unit_addr),
        .unit_data(unit_data), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .collision(collision), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model: each in-flight result is a record carrying the stage it currently occupies.
    typedef struct {
        int             pos;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } rec_t;
    rec_t q[$];
    int   m_cnt;
    bit   m_coll;

    function automatic void model_edge();
        rec_t nq[$];
        rec_t r;
        int   drops, n, w;
        if (reset) begin
            q.delete();
            m_cnt  = 0;
            m_coll = 0;
            return;
        end
        drops = 0;
        foreach (q[i]) begin
            if (q[i].pos < DEPTH) begin
                r = q[i];
                r.pos++;
                nq.push_back(r);
            end
        end
        for (int k = 1; k <= DEPTH; k++) begin
            n = 0;
            w = -1;
            for (int u = 0; u < NU; u++)
                if (unit_valid[u] && ST[u] == k) begin
                    n++;
                    if (w < 0) w = u;
                end
            if (n > 0) begin
                drops += n - 1;
                for (int i = nq.size() - 1; i >= 0; i--)
                    if (nq[i].pos == k) begin
                        drops++;
                        nq.delete(i);
                    end
                r.pos  = k;
                r.addr = unit_addr[w*AW +: AW];
                r.data = unit_data[w*DW +: DW];
                nq.push_back(r);
            end
        end
        q = nq;
        m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
        if (drops > 0) m_coll = 1;
    endfunction

    task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic          ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, bd;
        int            best;
        ev = 0; ea = '0; ed = '0;
        foreach (q[i])
            if (q[i].pos == DEPTH) begin
                ev = 1; ea = q[i].addr; ed = q[i].data;
            end
        cmp({tag, " wb_valid"}, wb_valid, ev);
        cmp({tag, " wb_addr"}, wb_addr, ea);
        cmp({tag, " wb_data"}, wb_data, ed);
        cmp({tag, " collision"}, collision, m_coll);
        cmp({tag, " drop_cnt"}, drop_cnt, m_cnt);
        for (int rp = 0; rp < NR; rp++) begin
            best = DEPTH + 1;
            bd   = '0;
            foreach (q[i])
                if (q[i].addr == lookup_addr[rp*AW +: AW] && q[i].pos < best) begin
                    best = q[i].pos; bd = q[i].data;
                end
            cmp($sformatf("%s hit%0d", tag, rp), lookup_hit[rp], best <= DEPTH);
            cmp($sformatf("%s ldata%0d", tag, rp), lookup_data[rp*DW +: DW], bd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr_in();
        unit_valid = '0;
        unit_addr  = '0;
        unit_data  = '0;
    endtask

    task automatic set_unit(input int u, input logic [AW-1:0] a, input logic [DW-1:0] d);
        unit_valid[u]          = 1'b1;
        unit_addr[u*AW +: AW]  = a;
        unit_data[u*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NU-1:0] uv;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW-1:0] la;
        logic          ewbv;
        logic [AW-1:0] ewba;
        logic [31:0]   ewbd;
        logic [NR-1:0] ehit;
        logic [31:0]   eld;
        logic [7:0]    ecnt;
        logic          ecoll;
    } vec_t;
    localparam int NV = 15;
    vec_t tv [NV];

    int            nwb;
    logic [DW-1:0] lastd;

    initial begin
        // Unit u gets addr+u and data+u; rows check state left by earlier rows, then clock.
        tv[0]  = '{5'b00001, 7'd5, 32'hA5, 7'd5, 1'b0, 7'd0, 32'h0,  3'b000, 32'h0,  8'd0, 1'b0};
        tv[1]  = '{5'b00000, 7'd0, 32'h0,  7'd5, 1'b0, 7'd0, 32'h0,  3'b111, 32'hA5, 8'd0, 1'b0};
        tv[2]  = tv[1];
        tv[3]  = tv[1];
        tv[4]  = tv[1];
        tv[5]  = tv[1];
        tv[6]  = '{5'b00000, 7'd0, 32'h0,  7'd5, 1'b1, 7'd5, 32'hA5, 3'b111, 32'hA5, 8'd0, 1'b0};
        tv[7]  = '{5'b10000, 7'd5, 32'h95, 7'd9, 1'b0, 7'd0, 32'h0,  3'b000, 32'h0,  8'd0, 1'b0};
        tv[8]  = '{5'b00000, 7'd0, 32'h0,  7'd9, 1'b1, 7'd9, 32'h99, 3'b111, 32'h99, 8'd0, 1'b0};
        tv[9]  = '{5'b00110, 7'd2, 32'h30, 7'd3, 1'b0, 7'd0, 32'h0,  3'b000, 32'h0,  8'd0, 1'b0};
        tv[10] = '{5'b00000, 7'd0, 32'h0,  7'd3, 1'b0, 7'd0, 32'h0,  3'b111, 32'h31, 8'd1, 1'b1};
        tv[11] = tv[10];
        tv[12] = tv[10];
        tv[13] = '{5'b00000, 7'd0, 32'h0,  7'd3, 1'b1, 7'd3, 32'h31, 3'b111, 32'h31, 8'd1, 1'b1};
        tv[14] = '{5'b00000, 7'd0, 32'h0,  7'd4, 1'b0, 7'd0, 32'h0,  3'b000, 32'h0,  8'd1, 1'b1};

        reset = 1'b1;
        clr_in();
        lookup_addr = '0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            clr_in();
            for (int u = 0; u < NU; u++)
                if (tv[i].uv[u]) set_unit(u, AW'(tv[i].addr + u), DW'(tv[i].data + u));
            lookup_addr = {NR{tv[i].la}};
            #1;
            cmp($sformatf("tbl%0d wb_valid", i), wb_valid, tv[i].ewbv);
            cmp($sformatf("tbl%0d wb_addr", i), wb_addr, tv[i].ewba);
            cmp($sformatf("tbl%0d wb_data", i), wb_data, DW'(tv[i].ewbd));
            cmp($sformatf("tbl%0d hit", i), lookup_hit, tv[i].ehit);
            for (int rp = 0; rp < NR; rp++)
                cmp($sformatf("tbl%0d ldata%0d", i, rp), lookup_data[rp*DW +: DW], DW'(tv[i].eld));
            cmp($sformatf("tbl%0d drop_cnt", i), drop_cnt, tv[i].ecnt);
            cmp($sformatf("tbl%0d collision", i), collision, tv[i].ecoll);
            tick();
        end

        // Younger result at stage 4 displaces an older same-address result sitting in s[3].
        do_reset();
        lookup_addr = {NR{7'd7}};
        set_unit(0, 7'd7, 128'd1);
        #1; chk_model("r38a"); tick();
        clr_in();
        #1; chk_model("r38b"); tick();
        set_unit(1, 7'd7, 128'd2);
        #1; chk_model("r38c"); tick();
        clr_in();
        nwb = 0;
        lastd = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (wb_valid) begin
                nwb++;
                lastd = wb_data;
            end
            chk_model("r38d");
            tick();
        end
        cmp("r38 wb count", nwb, 1);
        cmp("r38 wb data", lastd, 128'd2);
        cmp("r38 drop_cnt", drop_cnt, 8'd1);
        cmp("r38 collision", collision, 1'b1);

        // Same address staged twice: the younger (lower stage) value is forwarded.
        do_reset();
        lookup_addr = {NR{7'd12}};
        set_unit(1, 7'd12, 128'hAAAA);
        #1; chk_model("r39a"); tick();
        clr_in();
        set_unit(0, 7'd12, 128'hBBBB);
        #1; chk_model("r39b"); tick();
        clr_in();
        lookup_addr = {7'd12, 7'd13, 7'd12};
        #1;
        chk_model("r39c");
        cmp("r39 hit", lookup_hit, 3'b101);
        cmp("r39 ldata0", lookup_data[0 +: DW], 128'hBBBB);
        cmp("r39 ldata1", lookup_data[DW +: DW], 128'h0);
        cmp("r39 ldata2", lookup_data[2*DW +: DW], 128'hBBBB);
        tick();

        // Drive the drop counter past saturation, then reset with results in flight.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            clr_in();
            set_unit(1, AW'($urandom_range(0, 127)), DW'($urandom));
            set_unit(2, AW'($urandom_range(0, 127)), DW'($urandom));
            lookup_addr = AW*NR'($urandom);
            #1; chk_model("r40sat"); tick();
        end
        clr_in();
        set_unit(0, 7'd20, 128'h55);
        set_unit(3, 7'd21, 128'h66);
        #1;
        chk_model("r40pre");
        cmp("r40 drop_cnt sat", drop_cnt, 8'd255);
        tick();
        reset = 1'b1;
        for (int u = 0; u < NU; u++) set_unit(u, AW'(u + 20), DW'(u + 1));
        #1; chk_model("r40rst"); tick();
        reset = 1'b0;
        clr_in();
        lookup_addr = {7'd20, 7'd21, 7'd0};
        #1;
        cmp("r40 wb_valid", wb_valid, 1'b0);
        cmp("r40 wb_addr", wb_addr, 7'd0);
        cmp("r40 wb_data", wb_data, 128'd0);
        cmp("r40 hit", lookup_hit, 3'b000);
        for (int rp = 0; rp < NR; rp++)
            cmp($sformatf("r40 ldata%0d", rp), lookup_data[rp*DW +: DW], 128'd0);
        cmp("r40 collision", collision, 1'b0);
        cmp("r40 drop_cnt", drop_cnt, 8'd0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            #1;
            cmp("r40 no wb", wb_valid, 1'b0);
            chk_model("r40post");
            tick();
        end

        // Randomized traffic over a small address space so lookups hit often.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            clr_in();
            for (int u = 0; u < NU; u++)
                if ($urandom_range(0, 2) == 0)
                    set_unit(u, AW'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom});
            for (int rp = 0; rp < NR; rp++)
                lookup_addr[rp*AW +: AW] = AW'($urandom_range(0, 7));
            #1; chk_model("rnd"); tick();
        end
        reset = 1'b0;
        clr_in();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fwd_wb_pipe.md
FWD_WB_PIPE -- requirements
Module: fwd_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 128, result width in bits.
REQ-002 Parameter ADDR_W, default 7, destination register address width.
REQ-003 Parameter DEPTH, default 7, number of staging registers s[1..DEPTH].
REQ-004 Parameter NUM_UNITS, default 5, number of execution-unit result ports.
REQ-005 Parameter UNIT_STAGE, default {7,6,4,4,2}, 4 bits per unit, unit 0 in the LSBs; the stage into which each unit injects.
REQ-006 Parameter NUM_RD, default 3, number of forwarding lookup ports.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 unit_valid  in  NUM_UNITS  result from unit u is present this cycle.
REQ-010 unit_addr  in  NUM_UNITS*ADDR_W  destination address per unit.
REQ-011 unit_data  in  NUM_UNITS*DATA_W  result value per unit.
REQ-012 lookup_addr  in  NUM_RD*ADDR_W  register address to search, per port.
REQ-013 lookup_hit  out  NUM_RD  a valid staged entry matches.
REQ-014 lookup_data  out  NUM_RD*DATA_W  value of the matching entry; 0 on a miss.
REQ-015 wb_valid / wb_addr / wb_data  out  1 / ADDR_W / DATA_W  register-file write port, driven directly from s[DEPTH].
REQ-016 collision  out  1  sticky flag: at least one result has been dropped.
REQ-017 drop_cnt  out  8  saturating count of dropped results.

Function
REQ-018 Each stage holds {valid, addr, data}; s[0] is a constant empty entry.
REQ-019 Each edge with no injection into stage k: s[k] <= s[k-1], for k = 1..DEPTH.
REQ-020 A valid unit u with UNIT_STAGE[u]=k: s[k] <= {1, unit_addr[u], unit_data[u]} at that edge.
REQ-021 Latency: result sampled at edge E appears on wb_* after edge E+(DEPTH-k), i.e. DEPTH-k+1 cycles; a unit at stage DEPTH reaches wb 1 cycle later.
REQ-022 Several valid units targeting the same stage in one cycle: lowest unit index wins; every other such unit is dropped.
REQ-023 A valid s[k-1] displaced by an injection into s[k] is dropped.
REQ-024 An invalid s[k-1] displaced by an injection does not count as a drop.
REQ-025 Each drop sets collision; collision clears only on reset.
REQ-026 Per edge, drop_cnt <= min(255, drop_cnt + drops_this_cycle); it holds at 255 once saturated.
REQ-027 Lookup is combinational over s[1..DEPTH] only; same-cycle unit inputs are not visible.
REQ-028 On multiple lookup matches, the lowest stage index wins, because that entry is the youngest value.
REQ-029 Invalid stages never match; address 0 is an ordinary address.
REQ-030 wb_addr and wb_data equal s[DEPTH] contents even when wb_valid=0; the consumer qualifies with wb_valid.
REQ-031 A UNIT_STAGE value outside 1..DEPTH is an elaboration-time error.

Reset
REQ-032 While reset=1 at an edge, every stage clears to valid=0, addr=0, data=0; collision=0; drop_cnt=0; unit inputs are ignored that cycle.
REQ-033 In the cycle after reset deasserts: wb_valid=0, wb_addr=0, wb_data=0, lookup_hit all 0, lookup_data all 0.
REQ-034 Reset asserted mid-flight discards all staged results with no write-back and no drop counted.

Verification
REQ-035 Unit 0 (stage 2) valid, addr=5, data=0xA5 for one cycle -> wb_valid=1, addr=5, data=0xA5 exactly 6 cycles later, for one cycle.
REQ-036 Unit 4 (stage 7) addr=9 -> wb 1 cycle later; in the same cycle lookup_addr=9 misses, and it hits on the next cycle only while the entry is in s[7].
REQ-037 Units 1 and 2 (both stage 4) valid in one cycle with addrs 3 and 4 -> only addr 3 written back; collision=1; drop_cnt=1.
REQ-038 Unit 0 injects addr=7 data=1; 2 cycles later unit 1 (stage 4) injects addr=7 data=2 while the first entry sits in s[3] -> data=1 is dropped, drop_cnt increments, wb shows data=2 only.
REQ-039 addr 12 staged in s[2] with data=B and in s[5] with data=A -> lookup_hit=1, lookup_data=B on all ports querying 12.
REQ-040 Force 300 collisions, then assert reset with entries in flight -> drop_cnt stays at 255 until reset; after reset, no write-back and all outputs 0.
